// File: rtl/alu_seq_pkg.sv
// Shared types for the handshaked sequential ALU: opcodes, FSM states and
// iterative-unit modes.
package alu_seq_pkg;

    localparam int OP_W = 4;

    typedef enum logic [OP_W-1:0] {
        ALU_ADD  = 4'h0,
        ALU_SUB  = 4'h1,
        ALU_AND  = 4'h2,
        ALU_OR   = 4'h3,
        ALU_XOR  = 4'h4,
        ALU_SLT  = 4'h5,
        ALU_SLTU = 4'h6,
        ALU_SLL  = 4'h7,
        ALU_SRL  = 4'h8,
        ALU_SRA  = 4'h9,
        ALU_MUL  = 4'hA,
        ALU_DIVU = 4'hB,
        ALU_REMU = 4'hC
    } alu_op_e;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } state_e;

    typedef enum logic [1:0] {
        MD_MUL,
        MD_DIV,
        MD_REM
    } md_mode_e;

    function automatic logic is_iter_op(input logic [OP_W-1:0] op);
        return (op == ALU_MUL) || (op == ALU_DIVU) || (op == ALU_REMU);
    endfunction

endpackage

// File: rtl/alu_iter_muldiv.sv
// Iterative shift-add multiplier / restoring divider, one step per cycle,
// WIDTH steps per operation. 'done' and 'result' reflect the final step combinationally.
module alu_iter_muldiv
    import alu_seq_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  md_mode_e         mode,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result
);

    localparam int CW = $clog2(WIDTH);

    // acc: product sum or partial remainder; opb: multiplicand or divisor;
    // opq: multiplier (shifting out) or dividend/quotient (shifting through)
    logic [WIDTH-1:0] acc_reg, acc_next;
    logic [WIDTH-1:0] opb_reg, opb_next;
    logic [WIDTH-1:0] opq_reg, opq_next;
    logic [CW-1:0]    count_reg;
    logic             busy_reg;
    md_mode_e         mode_reg;

    logic [WIDTH:0]   shifted;
    logic [WIDTH-1:0] diff;
    logic             ge;

    always_comb begin
        acc_next = acc_reg;
        opb_next = opb_reg;
        opq_next = opq_reg;
        shifted  = '0;
        diff     = '0;
        ge       = 1'b0;
        if (mode_reg == MD_MUL) begin
            if (opq_reg[0]) begin
                acc_next = acc_reg + opb_reg;
            end
            opb_next = opb_reg << 1;
            opq_next = opq_reg >> 1;
        end else begin
            // A zero divisor always "fits": quotient fills with ones and the
            // remainder ends up as the dividend, which is the required result.
            shifted  = {acc_reg, opq_reg[WIDTH-1]};
            ge       = (shifted >= {1'b0, opb_reg});
            diff     = shifted[WIDTH-1:0] - opb_reg;
            acc_next = ge ? diff : shifted[WIDTH-1:0];
            opq_next = {opq_reg[WIDTH-2:0], ge};
        end
    end

    assign busy   = busy_reg;
    assign done   = busy_reg && (count_reg == CW'(WIDTH - 1));
    assign result = (mode_reg == MD_DIV) ? opq_next : acc_next;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_reg   <= '0;
            opb_reg   <= '0;
            opq_reg   <= '0;
            count_reg <= '0;
            busy_reg  <= 1'b0;
            mode_reg  <= MD_MUL;
        end else if (start) begin
            acc_reg   <= '0;
            opb_reg   <= b;
            opq_reg   <= a;
            count_reg <= '0;
            busy_reg  <= 1'b1;
            mode_reg  <= mode;
        end else if (busy_reg) begin
            acc_reg   <= acc_next;
            opb_reg   <= opb_next;
            opq_reg   <= opq_next;
            count_reg <= count_reg + CW'(1);
            if (done) begin
                busy_reg <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/alu_seq_muldiv.sv
// Handshaked ALU with single-cycle ops and optional iterative MUL/DIVU/REMU.
// Define ALU_MULDIV_EN to build the iterative unit; otherwise opcodes A-C are illegal.
module alu_seq_muldiv
    import alu_seq_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [OP_W-1:0]  op,
    input  logic [WIDTH-1:0] IN1,
    input  logic [WIDTH-1:0] IN2,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] OUT,
    output logic             Zero,
    output logic             illegal
);

    localparam int SHW = $clog2(WIDTH);

    state_e           state_reg, state_next;
    logic [WIDTH-1:0] out_reg, out_next;
    logic             zero_reg, zero_next;
    logic             illegal_reg, illegal_next;
    logic             load;

    logic [WIDTH-1:0] alu_res;
    logic             alu_illegal;
    logic [SHW-1:0]   shamt;
    logic             iter_done;
    logic [WIDTH-1:0] iter_result;

    assign shamt = IN2[SHW-1:0];

    always_comb begin
        alu_res     = '0;
        alu_illegal = 1'b0;
        case (op)
            ALU_ADD:  alu_res = IN1 + IN2;
            ALU_SUB:  alu_res = IN1 - IN2;
            ALU_AND:  alu_res = IN1 & IN2;
            ALU_OR:   alu_res = IN1 | IN2;
            ALU_XOR:  alu_res = IN1 ^ IN2;
            ALU_SLT:  alu_res = WIDTH'($signed(IN1) < $signed(IN2));
            ALU_SLTU: alu_res = WIDTH'(IN1 < IN2);
            ALU_SLL:  alu_res = IN1 << shamt;
            ALU_SRL:  alu_res = IN1 >> shamt;
            ALU_SRA:  alu_res = $unsigned($signed(IN1) >>> shamt);
            default:  alu_illegal = 1'b1;
        endcase
    end

`ifdef ALU_MULDIV_EN
    logic     iter_start;
    logic     iter_busy;
    md_mode_e iter_mode;

    assign iter_start = (state_reg == IDLE) && in_valid && is_iter_op(op);
    assign iter_mode  = (op == ALU_MUL)  ? MD_MUL :
                        (op == ALU_DIVU) ? MD_DIV : MD_REM;

    alu_iter_muldiv #(
        .WIDTH (WIDTH)
    ) u_iter (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (iter_start),
        .mode   (iter_mode),
        .a      (IN1),
        .b      (IN2),
        .busy   (iter_busy),
        .done   (iter_done),
        .result (iter_result)
    );
`else
    assign iter_done   = 1'b0;
    assign iter_result = '0;
`endif

    always_comb begin
        state_next   = state_reg;
        load         = 1'b0;
        out_next     = alu_res;
        illegal_next = alu_illegal;
        case (state_reg)
            IDLE: begin
                if (in_valid) begin
`ifdef ALU_MULDIV_EN
                    if (is_iter_op(op)) begin
                        state_next = BUSY;
                    end else
`endif
                    begin
                        state_next = DONE;
                        load       = 1'b1;
                    end
                end
            end
            BUSY: begin
                if (iter_done) begin
                    state_next   = DONE;
                    load         = 1'b1;
                    out_next     = iter_result;
                    illegal_next = 1'b0;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
        zero_next = (out_next == '0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Result registers change only on entry to DONE, so they hold while stalled
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_reg     <= '0;
            zero_reg    <= 1'b0;
            illegal_reg <= 1'b0;
        end else if (load) begin
            out_reg     <= out_next;
            zero_reg    <= zero_next;
            illegal_reg <= illegal_next;
        end
    end

    assign in_ready  = (state_reg == IDLE);
    assign out_valid = (state_reg == DONE);
    assign OUT       = out_reg;
    assign Zero      = zero_reg;
    assign illegal   = illegal_reg;

endmodule

// File: tb/tb_alu_seq_muldiv.sv
// Self-checking bench for alu_seq_muldiv (WIDTH = 32): directed corner cases plus
// random operations compared against an arithmetic reference model.
module tb_alu_seq_muldiv;

    localparam int WIDTH = 32;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              in_valid;
    logic              in_ready;
    logic [3:0]        op;
    logic [WIDTH-1:0]  in1;
    logic [WIDTH-1:0]  in2;
    logic              out_valid;
    logic              out_ready;
    logic [WIDTH-1:0]  out_data;
    logic              zero;
    logic              illegal;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    alu_seq_muldiv #(
        .WIDTH (WIDTH)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .IN1       (in1),
        .IN2       (in2),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .OUT       (out_data),
        .Zero      (zero),
        .illegal   (illegal)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Reference: result, illegal flag and extra cycles beyond single-cycle latency
    function automatic void ref_model(input logic [3:0] o, input logic [31:0] a,
                                      input logic [31:0] b, output logic [31:0] res,
                                      output logic ill, output int extra);
        longint unsigned ua = 64'(a);
        longint unsigned ub = 64'(b);
        int sh = int'(b % 32);
        res   = '0;
        ill   = 1'b0;
        extra = 0;
        case (o)
            4'h0: res = 32'(ua + ub);
            4'h1: res = 32'(ua + (64'h1_0000_0000 - ub));
            4'h2: res = a & b;
            4'h3: res = a | b;
            4'h4: res = a ^ b;
            4'h5: res = (int'(a) < int'(b)) ? 32'd1 : 32'd0;
            4'h6: res = (ua < ub) ? 32'd1 : 32'd0;
            4'h7: res = 32'(ua * (64'd1 << sh));
            4'h8: res = 32'(ua / (64'd1 << sh));
            4'h9: res = 32'(longint'(int'(a)) >>> sh);
`ifdef ALU_MULDIV_EN
            4'hA: begin res = 32'(ua * ub); extra = WIDTH; end
            4'hB: begin res = (b == 0) ? 32'hFFFF_FFFF : 32'(ua / ub); extra = WIDTH; end
            4'hC: begin res = (b == 0) ? a : 32'(ua % ub); extra = WIDTH; end
`endif
            default: ill = 1'b1;
        endcase
    endfunction

    // Called aligned #1 after a rising edge with in_ready expected high.
    task automatic do_op(input string tag, input logic [3:0] o, input logic [31:0] a,
                         input logic [31:0] b, input int hold);
        logic [31:0] eres;
        logic        eill;
        int          extra;
        int          lat;
        logic        stalled_ok;
        ref_model(o, a, b, eres, eill, extra);
        check_eq({tag, ".in_ready"}, 32'(in_ready), 32'd1);
        in_valid = 1'b1;
        op       = o;
        in1      = a;
        in2      = b;
        @(posedge clk);
        #1;
        in_valid   = 1'b0;
        op         = 4'($urandom);
        in1        = $urandom;
        in2        = $urandom;
        lat        = 0;
        stalled_ok = 1'b1;
        while (!out_valid && lat < 200) begin
            if (in_ready) stalled_ok = 1'b0;
            @(posedge clk);
            #1;
            lat++;
        end
        check_eq({tag, ".latency"}, 32'(lat), 32'(extra));
        if (extra > 0) check_eq({tag, ".busy_ready"}, 32'(stalled_ok), 32'd1);
        $display("op=%h a=%08h b=%08h -> OUT=%08h Zero=%0b illegal=%0b lat=%0d",
                 o, a, b, out_data, zero, illegal, lat);
        check_eq({tag, ".out"}, out_data, eres);
        check_eq({tag, ".zero"}, 32'(zero), 32'(eres == 0));
        check_eq({tag, ".illegal"}, 32'(illegal), 32'(eill));
        for (int i = 0; i < hold; i++) begin
            @(posedge clk);
            #1;
            check_eq({tag, ".hold_valid"}, 32'(out_valid), 32'd1);
            check_eq({tag, ".hold_out"}, out_data, eres);
            check_eq({tag, ".hold_ready"}, 32'(in_ready), 32'd0);
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check_eq({tag, ".retired"}, 32'(out_valid), 32'd0);
        check_eq({tag, ".ready_after"}, 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        op        = '0;
        in1       = '0;
        in2       = '0;
        out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check_eq("reset.in_ready", 32'(in_ready), 32'd1);
        check_eq("reset.out_valid", 32'(out_valid), 32'd0);
        check_eq("reset.out", out_data, 32'd0);
        check_eq("reset.zero", 32'(zero), 32'd0);
        check_eq("reset.illegal", 32'(illegal), 32'd0);

        do_op("add_wrap", 4'h0, 32'hFFFF_FFFF, 32'd1, 0);
        do_op("slt", 4'h5, 32'hFFFF_FFFF, 32'd1, 0);
        do_op("sltu", 4'h6, 32'hFFFF_FFFF, 32'd1, 0);
        do_op("sra", 4'h9, 32'h8000_0000, 32'd33, 0);
        do_op("mul", 4'hA, 32'h0001_0000, 32'h0001_0003, 0);
        do_op("divu", 4'hB, 32'd100, 32'd7, 0);
        do_op("remu", 4'hC, 32'd100, 32'd7, 0);
        do_op("divu0", 4'hB, 32'd5, 32'd0, 0);
        do_op("remu0", 4'hC, 32'd5, 32'd0, 0);
        do_op("add_hold", 4'h0, 32'd3, 32'd4, 10);
        do_op("ill_e", 4'hE, 32'h1234_5678, 32'h9ABC_DEF0, 0);

        for (int n = 0; n < 40; n++) begin
            logic [3:0]  ro;
            logic [31:0] ra;
            logic [31:0] rb;
            ro = 4'($urandom_range(0, 15));
            ra = ($urandom_range(0, 7) == 0) ? 32'h8000_0000 : $urandom;
            rb = ($urandom_range(0, 5) == 0) ? 32'd0 : $urandom;
            if ($urandom_range(0, 3) == 0) rb = rb % 256;
            do_op("rand", ro, ra, rb, $urandom_range(0, 3));
        end

        // Reset in the middle of a MUL (or of the illegal result in the default build)
        in_valid = 1'b1;
        op       = 4'hA;
        in1      = 32'h0001_0000;
        in2      = 32'h0001_0003;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check_eq("midrst.out_valid", 32'(out_valid), 32'd0);
        check_eq("midrst.out", out_data, 32'd0);
        check_eq("midrst.zero", 32'(zero), 32'd0);
        check_eq("midrst.illegal", 32'(illegal), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check_eq("midrst.in_ready", 32'(in_ready), 32'd1);
        check_eq("midrst.no_result", 32'(out_valid), 32'd0);
        do_op("post_rst_add", 4'h0, 32'd1, 32'd1, 0);
        do_op("op_a", 4'hA, 32'd6, 32'd7, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
